// File: rtl/cmos_lane_driver.sv
// cmos_lane_driver: precharge/evaluate driver and result capture for a dual-rail CMOS XOR lane.
// Optional LANE_CHECK_EN adds err_o/err_cnt lane-result checking.
module cmos_lane_driver #(
  parameter int BIT_SIZE      = 4,
  parameter int SETTLE_CYCLES = 3,
  parameter int CNT_W         = 4
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BIT_SIZE-1:0] in_x,
  input  logic [BIT_SIZE-1:0] in_k,
  output logic [BIT_SIZE-1:0] x_top,
  output logic [BIT_SIZE-1:0] x_bar_top,
  output logic [BIT_SIZE-1:0] k_top,
  output logic [BIT_SIZE-1:0] k_bar_top,
  input  logic [BIT_SIZE-1:0] s_top,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BIT_SIZE-1:0] out_s,
  output logic                busy
`ifdef LANE_CHECK_EN
  ,
  output logic                err_o,
  output logic [7:0]          err_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, PRECH, DRIVE, HOLD} state_t;
  state_t state_q, state_d;
  logic [BIT_SIZE-1:0] x_q, x_d, k_q, k_d, out_s_q, out_s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic out_valid_q, out_valid_d;
  logic drive, accept, capture;
  assign in_ready  = state_q == IDLE || (state_q == HOLD && out_ready);
  assign accept    = in_valid && in_ready;
  assign drive     = state_q == DRIVE;
  assign capture   = drive && cnt_q == '0;
  // Rails are forced low outside DRIVE so true/complement can never overlap.
  assign x_top     = drive ? x_q : '0;
  assign x_bar_top = drive ? ~x_q : '0;
  assign k_top     = drive ? k_q : '0;
  assign k_bar_top = drive ? ~k_q : '0;
  assign out_valid = out_valid_q;
  assign out_s     = out_s_q;
  assign busy      = state_q != IDLE;
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    k_d         = k_q;
    cnt_d       = cnt_q;
    out_s_d     = out_s_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE, HOLD: begin
        if (state_q == HOLD && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
        if (accept) begin
          x_d     = in_x;
          k_d     = in_k;
          state_d = PRECH;
        end
      end
      PRECH: begin
        state_d = DRIVE;
        cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
      end
      DRIVE: begin
        cnt_d       = capture ? cnt_q : cnt_q - CNT_W'(1);
        out_s_d     = capture ? s_top : out_s_q;
        out_valid_d = capture ? 1'b1 : out_valid_q;
        state_d     = capture ? HOLD : DRIVE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      k_q         <= '0;
      cnt_q       <= '0;
      out_s_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      out_s_q     <= out_s_d;
      out_valid_q <= out_valid_d;
    end
  end
`ifdef LANE_CHECK_EN
  logic err_q, err_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic bad;
  assign bad     = capture && s_top != (x_q ^ k_q);
  assign err_o   = err_q;
  assign err_cnt = err_cnt_q;
  always_comb begin
    err_d     = err_q | bad;
    err_cnt_d = (bad && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end
`endif
endmodule

// File: tb/tb_cmos_lane_driver.sv
// tb_cmos_lane_driver: randomized and directed checks of cmos_lane_driver against a transaction-timing model.
// Build with LANE_CHECK_EN defined to also exercise err_o/err_cnt.
module tb_cmos_lane_driver;
  localparam int S = 3;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, busy;
  logic [3:0] in_x = '0, in_k = '0, x_top, x_bar_top, k_top, k_bar_top, s_top, out_s;
`ifdef LANE_CHECK_EN
  logic err_o;
  logic [7:0] err_cnt;
`endif
  bit fault_en = 1'b0;
  int n_tests = 0, n_fail = 0;
  int cyc = 0, t_acc = 0;
  bit outst = 1'b0;
  logic [3:0] xm = '0, km = '0;
  int err_m = 0;

  cmos_lane_driver dut (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_k(in_k), .x_top(x_top), .x_bar_top(x_bar_top), .k_top(k_top),
    .k_bar_top(k_bar_top), .s_top(s_top), .out_valid(out_valid), .out_ready(out_ready),
    .out_s(out_s), .busy(busy)
`ifdef LANE_CHECK_EN
    , .err_o(err_o), .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] lane(input logic [3:0] x, k);
    return (fault_en && x == 4'h1 && k == 4'h0) ? 4'h0 : x ^ k;
  endfunction
  assign s_top = lane(x_top, k_top);

  task automatic check(input string tag, input logic [31:0] got, exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    bit ready_ph, drv;
    ready_ph = outst && cyc >= t_acc + 1 + S;
    drv = outst && !ready_ph && cyc >= t_acc + 1;
    check("out_valid", out_valid, ready_ph);
    if (ready_ph) check("out_s", out_s, lane(xm, km));
    check("rails", {x_top, x_bar_top, k_top, k_bar_top}, drv ? {xm, ~xm, km, ~km} : 16'h0);
    check("rail_excl", (x_top & x_bar_top) | (k_top & k_bar_top), 0);
    check("busy", busy, outst);
`ifdef LANE_CHECK_EN
    check("err_o", err_o, err_m != 0);
    check("err_cnt", err_cnt, err_m);
`endif
  endtask

  task automatic step(input logic iv, input logic [3:0] x, k, input logic ordy);
    bit exp_rdy, ohs, ihs;
    in_valid = iv; in_x = x; in_k = k; out_ready = ordy;
    #1;
    exp_rdy = !outst || (cyc >= t_acc + 1 + S && ordy);
    check("in_ready", in_ready, exp_rdy);
    ohs = outst && cyc >= t_acc + 1 + S && ordy;
    ihs = iv && exp_rdy;
    @(posedge clk);
    cyc++;
    if (ohs) outst = 1'b0;
    if (ihs) begin
      outst = 1'b1; t_acc = cyc; xm = x; km = k;
    end
    if (outst && cyc == t_acc + 1 + S && lane(xm, km) != (xm ^ km) && err_m < 255) err_m++;
    #1;
    check_outputs();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_rails", {x_top, x_bar_top, k_top, k_bar_top}, 0);
    check("rst_valid", out_valid, 0);
    check("rst_out_s", out_s, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
    // single op then backpressure then back-to-back
    step(1, 4'hA, 4'h3, 1);
    repeat (S + 1) step(0, 4'h0, 4'h0, 0);
    check("single_s", out_s, 4'h9);
    check("single_valid", out_valid, 1);
    repeat (5) step(0, $urandom, $urandom, 0);
    check("bp_s", out_s, 4'h9);
    step(1, 4'h5, 4'hF, 1);
    check("b2b_busy", busy, 1);
    repeat (S + 1) step(0, $urandom, $urandom, 1);
    check("b2b_s", out_s, 4'hA);
    repeat (2) step(0, 4'h0, 4'h0, 1);
    // reset in DRIVE with one settle cycle left
    step(1, 4'h6, 4'h9, 1);
    step(0, 4'h0, 4'h0, 1);
    step(0, 4'h0, 4'h0, 1);
    check("pre_rst_rails", x_top, 4'h6);
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    check("mid_rst_rails", {x_top, x_bar_top, k_top, k_bar_top}, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    outst = 1'b0; err_m = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (S + 3) step(0, $urandom, $urandom, 1);
    // random traffic
    for (int i = 0; i < 800; i++) step($urandom % 2, $urandom, $urandom, ($urandom % 4) != 0);
    repeat (S + 2) step(0, 4'h0, 4'h0, 1);
    // faulty lane result is captured as-is
    fault_en = 1'b1;
    step(1, 4'h1, 4'h0, 1);
    repeat (S + 1) step(0, 4'h0, 4'h0, 1);
    check("fault_s", out_s, 4'h0);
`ifdef LANE_CHECK_EN
    check("fault_err_o", err_o, 1);
    check("fault_err_cnt", err_cnt, 1);
    for (int i = 0; i < 300; i++) step(1, 4'h1, 4'h0, 1);
    repeat (S + 2) step(0, 4'h0, 4'h0, 1);
    check("err_sat", err_cnt, 8'hFF);
`endif
    repeat (2) step(0, 4'h0, 4'h0, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
